// File: rtl/qic117_step_counter.sv
// QIC-117 STEP pulse counter: synchronizes the raw STEP pin, qualifies pulses
// by minimum asserted width, counts them and closes the command after a
// silence timeout with a one-cycle command_valid strobe.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no command open, waiting for the first qualified pulse
// COUNT | command open, counting pulses and timing the silence window
// EMIT  | one-cycle strobe presenting the closed command downstream
module qic117_step_counter #(
    parameter int TIMEOUT_CYCLES   = 20_000_000,
    parameter int MIN_WIDTH_CYCLES = 20,
    parameter bit STEP_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step_in,
    input  logic       enable,
    output logic [5:0] pulse_count,
    output logic       command_valid,
    output logic       overflow,
    output logic       busy,
    output logic [5:0] live_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int WW = $clog2(MIN_WIDTH_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_CYCLES);
    localparam logic [WW-1:0] MIN_WIDTH_VAL = WW'(MIN_WIDTH_CYCLES);
    // Synchronizer rest level is the deasserted level of the pin.
    localparam logic STEP_IDLE_LVL = STEP_ACTIVE_LOW;
    localparam logic [5:0] COUNT_MAX = 6'd63;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_act_q, prev_act_d;
    logic [WW-1:0] width_q, width_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [5:0] count_q, count_d;
    logic flag_q, flag_d;
    logic [5:0] pulse_count_q, pulse_count_d;
    logic ovf_out_q, ovf_out_d;

    logic step_act;
    logic qual;

    assign step_act = sync2_q ^ STEP_ACTIVE_LOW;

    // Trailing edge of a pulse that stayed asserted for at least the minimum width.
    assign qual = enable & prev_act_q & ~step_act & (width_q == MIN_WIDTH_VAL);

    // Input path: synchronizer, edge history and saturating width counter.
    always_comb begin
        sync1_d    = step_in;
        sync2_d    = sync1_q;
        prev_act_d = step_act;
        width_d    = width_q;
        if (!enable || !step_act) begin
            width_d = '0;
        end else if (width_q != MIN_WIDTH_VAL) begin
            width_d = width_q + WW'(1);
        end
    end

    // Next-state and command datapath; qualified pulses win over the timeout.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        flag_d        = flag_q;
        timer_d       = timer_q;
        pulse_count_d = pulse_count_q;
        ovf_out_d     = 1'b0;
        case (state_q)
            ST_COUNT: begin
                if (qual) begin
                    if (count_q == COUNT_MAX) begin
                        flag_d = 1'b1;
                    end else begin
                        count_d = count_q + 6'd1;
                    end
                    timer_d = '0;
                end else if (timer_q == TIMEOUT_VAL) begin
                    pulse_count_d = count_q;
                    ovf_out_d     = flag_q;
                    count_d       = '0;
                    flag_d        = 1'b0;
                    timer_d       = '0;
                    state_d       = ST_EMIT;
                end else if (!step_act) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                // IDLE and EMIT both accept the first pulse of a new command.
                state_d = ST_IDLE;
                count_d = '0;
                flag_d  = 1'b0;
                timer_d = '0;
                if (qual) begin
                    count_d = 6'd1;
                    state_d = ST_COUNT;
                end
            end
        endcase
        if (!enable) begin
            state_d = ST_IDLE;
            count_d = '0;
            flag_d  = 1'b0;
            timer_d = '0;
        end
    end

    // Input path registers; the synchronizer rests at the deasserted level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= STEP_IDLE_LVL;
            sync2_q    <= STEP_IDLE_LVL;
            prev_act_q <= 1'b0;
            width_q    <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_act_q <= prev_act_d;
            width_q    <= width_d;
        end
    end

    // FSM state and command registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            count_q       <= '0;
            flag_q        <= 1'b0;
            timer_q       <= '0;
            pulse_count_q <= '0;
            ovf_out_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            flag_q        <= flag_d;
            timer_q       <= timer_d;
            pulse_count_q <= pulse_count_d;
            ovf_out_q     <= ovf_out_d;
        end
    end

    assign pulse_count   = pulse_count_q;
    assign command_valid = (state_q == ST_EMIT);
    assign overflow      = command_valid & ovf_out_q;
    assign busy          = (state_q == ST_COUNT);
    assign live_count    = count_q;

endmodule

// File: tb/tb_qic117_step_counter.sv
// Bench for qic117_step_counter: directed STEP patterns, expected commands
// queued by the stimulus and checked by an independent strobe monitor.
module tb_qic117_step_counter;

    logic       clk;
    logic       reset;
    logic       step_in;
    logic       enable;
    logic [5:0] pulse_count;
    logic       command_valid;
    logic       overflow;
    logic       busy;
    logic [5:0] live_count;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic prev_cv = 1'b0;

    // Strobe lands 3 cycles (pin to count) + 101 cycles (close) after release.
    localparam int CLOSE_LAT = 104;

    typedef struct {
        int cnt;
        int ovf;
        int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    qic117_step_counter #(
        .TIMEOUT_CYCLES  (100),
        .MIN_WIDTH_CYCLES(4),
        .STEP_ACTIVE_LOW (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .step_in      (step_in),
        .enable       (enable),
        .pulse_count  (pulse_count),
        .command_valid(command_valid),
        .overflow     (overflow),
        .busy         (busy),
        .live_count   (live_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one active-low pulse of w cycles followed by an 8-cycle gap.
    task automatic pulse(input int w, output int rel);
        step_in = 1'b0;
        tick(w);
        step_in = 1'b1;
        rel = cyc;
        tick(8);
    endtask

    task automatic expect_cmd(input int cnt, input int ovf, input int rel);
        exp_t x;
        x.cnt = cnt;
        x.ovf = ovf;
        x.cyc = rel + CLOSE_LAT;
        sb.push_back(x);
    endtask

    // Monitor: every strobe must match the oldest queued command.
    always @(negedge clk) begin
        if (reset) begin
            prev_cv <= 1'b0;
        end else begin
            if (command_valid) begin
                chk("cv_consecutive", int'(prev_cv), 0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe actual=count %0d at cycle %0d required=no strobe",
                             pulse_count, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_count", int'(pulse_count), e.cnt);
                    chk("overflow", int'(overflow), e.ovf);
                    chk("strobe_cycle", cyc, e.cyc);
                    chk("busy_at_strobe", int'(busy), 0);
                end
            end
            prev_cv <= command_valid;
        end
    end

    initial begin
        int rel;
        int r1;
        reset   = 1'b1;
        step_in = 1'b1;
        enable  = 1'b1;
        tick(3);
        chk("rst_pulse_count", int'(pulse_count), 0);
        chk("rst_command_valid", int'(command_valid), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_live_count", int'(live_count), 0);
        reset = 1'b0;
        tick(3);

        // Basic 4-pulse command.
        for (int i = 0; i < 4; i++) pulse(8, rel);
        chk("basic_live", int'(live_count), 4);
        chk("basic_busy", int'(busy), 1);
        expect_cmd(4, 0, rel);
        tick(120);
        chk("basic_idle_live", int'(live_count), 0);

        // Glitch rejection: short pulses between valid ones.
        pulse(8, rel);
        pulse(2, rel);
        pulse(8, rel);
        pulse(2, rel);
        pulse(8, rel);
        chk("glitch_live", int'(live_count), 3);
        expect_cmd(3, 0, rel);
        tick(120);

        // Timeout race: second pulse lands when the timer would hit the limit.
        step_in = 1'b0;
        tick(8);
        step_in = 1'b1;
        r1 = cyc;
        tick(100);
        chk("race_busy_before", int'(busy), 1);
        step_in = 1'b0;
        tick(8);
        step_in = 1'b1;
        rel = cyc;
        tick(8);
        chk("race_live", int'(live_count), 2);
        chk("race_span", rel - r1, 108);
        expect_cmd(2, 0, rel);
        tick(120);

        // Saturation with overflow, then a clean single-pulse command.
        for (int i = 0; i < 70; i++) pulse(8, rel);
        chk("sat_live", int'(live_count), 63);
        expect_cmd(63, 1, rel);
        tick(120);
        pulse(8, rel);
        expect_cmd(1, 0, rel);
        tick(120);

        // Abort via enable, and pulses ignored while disabled.
        for (int i = 0; i < 5; i++) pulse(8, rel);
        chk("abort_live_before", int'(live_count), 5);
        enable = 1'b0;
        tick(10);
        chk("abort_live", int'(live_count), 0);
        chk("abort_busy", int'(busy), 0);
        pulse(8, rel);
        chk("disabled_live", int'(live_count), 0);
        enable = 1'b1;
        tick(150);
        chk("abort_live_after", int'(live_count), 0);

        // Stuck-asserted line holds the timer until release.
        pulse(8, rel);
        pulse(8, rel);
        step_in = 1'b0;
        tick(300);
        chk("stuck_busy", int'(busy), 1);
        chk("stuck_live", int'(live_count), 2);
        step_in = 1'b1;
        rel = cyc;
        tick(8);
        chk("stuck_release_live", int'(live_count), 3);
        expect_cmd(3, 0, rel);
        tick(120);

        // Reset mid-command.
        for (int i = 0; i < 6; i++) pulse(8, rel);
        chk("prereset_live", int'(live_count), 6);
        reset = 1'b1;
        #1;
        chk("midrst_live", int'(live_count), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_cv", int'(command_valid), 0);
        chk("midrst_pulse_count", int'(pulse_count), 0);
        tick(3);
        reset = 1'b0;
        tick(150);
        chk("postrst_live", int'(live_count), 0);
        pulse(8, rel);
        pulse(8, rel);
        expect_cmd(2, 0, rel);
        tick(120);

        chk("missing_strobes", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
